// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the processing-element sequencer.
//   - DATA_W            : default datapath width (activations, weights, psums)
//   - IFMAP_AW          : ifmap scratchpad address width
//   - FILT_AW / PSUM_AW : filter and psum scratchpad address widths
//   - ST_* / pe_state_e : sequencer FSM state encoding
package pe_pkg;

    localparam int DATA_W   = 8;
    localparam int IFMAP_AW = 4;
    localparam int FILT_AW  = 6;
    localparam int PSUM_AW  = 6;

    localparam logic [1:0] ST_IDLE_C    = 2'd0;
    localparam logic [1:0] ST_LOAD_C    = 2'd1;
    localparam logic [1:0] ST_COMPUTE_C = 2'd2;
    localparam logic [1:0] ST_DRAIN_C   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_C,
        ST_LOAD    = ST_LOAD_C,
        ST_COMPUTE = ST_COMPUTE_C,
        ST_DRAIN   = ST_DRAIN_C
    } pe_state_e;

endpackage

// File: rtl/pe_mac_acc.sv
// pe_mac_acc: multiply-accumulate register with synchronous clear.
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : load zero into the accumulator (wins over en)
//   en         : accumulate a*b into the register
//   a, b       : unsigned operands
//   acc        : registered accumulator value
//   sum        : acc + a*b, combinational (used to write a result without
//                waiting for the accumulator to update)
// Product and sum both wrap modulo 2^DATA_W.
module pe_mac_acc
    import pe_pkg::*;
#(
    parameter int DATA_W = pe_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] prod;

    // Context width is DATA_W, so the product is truncated as intended.
    assign prod = a * b;
    assign sum  = acc + prod;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/pe_sequencer.sv
// pe_sequencer: row-stationary PE control. Loads an ifmap row (W words) and a
// filter row (S taps) into external scratchpads, computes the 1-D convolution
// into the psum scratchpad, then streams the W-S+1 results out.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   cfg_valid/cfg_ready/cfg_w/cfg_s job configuration; cfg_err pulses on a bad job
//   ifmap_* / filt_* (valid/ready)  load streams
//   ifmap_addr.. / filt_addr..      scratchpad strobes (read latency 1 cycle)
//   psum_addr..                     psum scratchpad strobes
//   psum_in_*                       external psum operand (PE_PSUM_ACC_EN only)
//   psum_out_*                      result stream; busy, done (pulse)
//   dbg_state                       current FSM state
// Build option: define PE_PSUM_ACC_EN to add psum_in_data to every result,
// stalling the write cycle until psum_in handshakes.
// Handshakes: a word moves on a rising edge where valid && ready are both high;
// a producer holding valid keeps its data stable until that edge.
module pe_sequencer
    import pe_pkg::*;
#(
    parameter int DATA_W      = pe_pkg::DATA_W,
    parameter int IFMAP_DEPTH = 16,
    parameter int FILT_DEPTH  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [4:0]          cfg_w,
    input  logic [3:0]          cfg_s,
    output logic                cfg_err,
    input  logic                ifmap_valid,
    output logic                ifmap_ready,
    input  logic [DATA_W-1:0]   ifmap_data,
    input  logic                filt_valid,
    output logic                filt_ready,
    input  logic [DATA_W-1:0]   filt_data,
    output logic [IFMAP_AW-1:0] ifmap_addr,
    output logic                ifmap_wr,
    output logic                ifmap_rd,
    output logic [DATA_W-1:0]   ifmap_wdata,
    input  logic [DATA_W-1:0]   ifmap_rdata,
    output logic [FILT_AW-1:0]  filt_addr,
    output logic                filt_wr,
    output logic                filt_rd,
    output logic [DATA_W-1:0]   filt_wdata,
    input  logic [DATA_W-1:0]   filt_rdata,
    output logic [PSUM_AW-1:0]  psum_addr,
    output logic                psum_wr,
    output logic                psum_rd,
    output logic [DATA_W-1:0]   psum_wdata,
    input  logic [DATA_W-1:0]   psum_rdata,
    input  logic                psum_in_valid,
    output logic                psum_in_ready,
    input  logic [DATA_W-1:0]   psum_in_data,
    output logic                psum_out_valid,
    input  logic                psum_out_ready,
    output logic [DATA_W-1:0]   psum_out_data,
    output logic                busy,
    output logic                done,
    output logic [1:0]          dbg_state
);

    localparam logic [4:0] MAX_W = 5'(IFMAP_DEPTH);
    localparam logic [6:0] MAX_S = 7'(FILT_DEPTH);

    pe_state_e   state;
    logic        rst_done;      // holds cfg_ready low until the first edge after reset
    logic [4:0]  w_q;
    logic [3:0]  s_q;
    logic [4:0]  icnt, fcnt;    // words accepted per load stream
    logic [3:0]  j, k;          // output index, tap index (k == s_q: write cycle)
    logic        tap_pend;      // a tap read was issued last cycle
    logic [3:0]  didx;          // drain read index
    logic        dpend;         // drain read outstanding

    logic        in_load, in_comp, in_drain;
    logic        ifmap_fire, filt_fire;
    logic        rd_phase, wr_phase, wr_fire;
    logic        cfg_ok, out_last, drain_last, drain_issue;
    logic [4:0]  last_j;
    logic [DATA_W-1:0] mac_acc, mac_sum, wr_add, wr_val;

    assign in_load  = (state == ST_LOAD);
    assign in_comp  = (state == ST_COMPUTE);
    assign in_drain = (state == ST_DRAIN);
    assign busy      = (state != ST_IDLE);
    assign cfg_ready = rst_done && (state == ST_IDLE);
    assign dbg_state = state;

    assign cfg_ok = (cfg_s != 4'd0) && ({1'b0, cfg_s} <= cfg_w) &&
                    (cfg_w <= MAX_W) && ({3'b0, cfg_s} <= MAX_S);

    assign ifmap_ready = in_load && (icnt < w_q);
    assign filt_ready  = in_load && (fcnt < {1'b0, s_q});
    assign ifmap_fire  = ifmap_valid && ifmap_ready;
    assign filt_fire   = filt_valid && filt_ready;

    assign last_j     = w_q - {1'b0, s_q};
    assign rd_phase   = in_comp && (k < s_q);
    assign wr_phase   = in_comp && (k == s_q);
    assign out_last   = ({1'b0, j} == last_j);
    assign drain_last = ({1'b0, didx} == last_j);
    assign drain_issue = in_drain && !psum_out_valid && !dpend;

`ifdef PE_PSUM_ACC_EN
    assign psum_in_ready = wr_phase;
    assign wr_fire       = wr_phase && psum_in_valid;
    assign wr_add        = psum_in_data;
`else
    logic unused_psum_in;
    assign unused_psum_in = ^{psum_in_valid, psum_in_data};
    assign psum_in_ready  = 1'b0;
    assign wr_fire        = wr_phase;
    assign wr_add         = '0;
`endif

    // The last tap's data arrives in the write cycle itself, so the first
    // write cycle uses the combinational sum; stalled cycles after it see the
    // accumulator, which has absorbed that tap by then.
    assign wr_val = (tap_pend ? mac_sum : mac_acc) + wr_add;

    pe_mac_acc #(.DATA_W(DATA_W)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (rd_phase && (k == 4'd0)),
        .en    (tap_pend),
        .a     (ifmap_rdata),
        .b     (filt_rdata),
        .acc   (mac_acc),
        .sum   (mac_sum)
    );

    always_comb begin
        ifmap_addr  = '0;
        filt_addr   = '0;
        psum_addr   = '0;
        if (in_load) begin
            ifmap_addr = icnt[3:0];
            filt_addr  = {2'b0, fcnt[3:0]};
        end else if (rd_phase) begin
            ifmap_addr = j + k;
            filt_addr  = {2'b0, k};
        end
        if (wr_phase) begin
            psum_addr = {2'b0, j};
        end else if (drain_issue) begin
            psum_addr = {2'b0, didx};
        end
        ifmap_wr    = ifmap_fire;
        ifmap_wdata = ifmap_fire ? ifmap_data : '0;
        ifmap_rd    = rd_phase;
        filt_wr     = filt_fire;
        filt_wdata  = filt_fire ? filt_data : '0;
        filt_rd     = rd_phase;
        psum_wr     = wr_fire;
        psum_wdata  = wr_fire ? wr_val : '0;
        psum_rd     = drain_issue;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            rst_done       <= 1'b0;
            w_q            <= '0;
            s_q            <= '0;
            icnt           <= '0;
            fcnt           <= '0;
            j              <= '0;
            k              <= '0;
            tap_pend       <= 1'b0;
            didx           <= '0;
            dpend          <= 1'b0;
            psum_out_valid <= 1'b0;
            psum_out_data  <= '0;
            done           <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
            tap_pend <= rd_phase;
            case (state)
                ST_IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        if (cfg_ok) begin
                            w_q   <= cfg_w;
                            s_q   <= cfg_s;
                            icnt  <= '0;
                            fcnt  <= '0;
                            state <= ST_LOAD;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (ifmap_fire) icnt <= icnt + 5'd1;
                    if (filt_fire)  fcnt <= fcnt + 5'd1;
                    if ((icnt == w_q) && (fcnt == {1'b0, s_q})) begin
                        j     <= '0;
                        k     <= '0;
                        state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (rd_phase) begin
                        k <= k + 4'd1;
                    end else if (wr_fire) begin
                        if (out_last) begin
                            didx  <= '0;
                            dpend <= 1'b0;
                            state <= ST_DRAIN;
                        end else begin
                            j <= j + 4'd1;
                            k <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_issue) dpend <= 1'b1;
                    if (dpend) begin
                        psum_out_data  <= psum_rdata;
                        psum_out_valid <= 1'b1;
                        dpend          <= 1'b0;
                    end
                    if (psum_out_valid && psum_out_ready) begin
                        psum_out_valid <= 1'b0;
                        if (drain_last) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            didx <= didx + 4'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer: stimulus and checking for pe_sequencer, with behavioural
// scratchpad memories (1-cycle read latency) and a convolution reference model.
module tb_pe_sequencer;
    import pe_pkg::*;

`ifdef PE_PSUM_ACC_EN
    localparam int PSUM_ADD = 10;
`else
    localparam int PSUM_ADD = 0;
`endif

    typedef struct {
        int               w;
        int               s;
        logic [15:0][7:0] ifm;
        logic [15:0][7:0] flt;
        logic [15:0][7:0] exp_o;
        int               mode;   // 0 random ready, 1 hold ready low 5 cycles, 2 always ready
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic cfg_valid, cfg_ready, cfg_err;
    logic [4:0] cfg_w;
    logic [3:0] cfg_s;
    logic ifmap_valid, ifmap_ready, filt_valid, filt_ready;
    logic [7:0] ifmap_data, filt_data;
    logic [3:0] ifmap_addr;
    logic ifmap_wr, ifmap_rd, filt_wr, filt_rd, psum_wr, psum_rd;
    logic [5:0] filt_addr, psum_addr;
    logic [7:0] ifmap_wdata, ifmap_rdata, filt_wdata, filt_rdata, psum_wdata, psum_rdata;
    logic psum_in_valid, psum_in_ready;
    logic [7:0] psum_in_data;
    logic psum_out_valid, psum_out_ready;
    logic [7:0] psum_out_data;
    logic busy, done;
    logic [1:0] dbg_state;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];
    vec_t vecs[6];
    int cur_w, cur_s;
    logic [7:0] cur_ifm[16];
    logic [7:0] cur_flt[16];

    logic [7:0] ifm_mem[16];
    logic [7:0] flt_mem[64];
    logic [7:0] ps_mem[64];

    pe_sequencer dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_w(cfg_w), .cfg_s(cfg_s), .cfg_err(cfg_err),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_data(ifmap_data),
        .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_data(filt_data),
        .ifmap_addr(ifmap_addr), .ifmap_wr(ifmap_wr), .ifmap_rd(ifmap_rd),
        .ifmap_wdata(ifmap_wdata), .ifmap_rdata(ifmap_rdata),
        .filt_addr(filt_addr), .filt_wr(filt_wr), .filt_rd(filt_rd),
        .filt_wdata(filt_wdata), .filt_rdata(filt_rdata),
        .psum_addr(psum_addr), .psum_wr(psum_wr), .psum_rd(psum_rd),
        .psum_wdata(psum_wdata), .psum_rdata(psum_rdata),
        .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in_data(psum_in_data),
        .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready), .psum_out_data(psum_out_data),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scratchpad models
    always @(posedge clk) begin
        if (ifmap_wr) ifm_mem[ifmap_addr] <= ifmap_wdata;
        if (ifmap_rd) ifmap_rdata <= ifm_mem[ifmap_addr];
        if (filt_wr)  flt_mem[filt_addr] <= filt_wdata;
        if (filt_rd)  filt_rdata <= flt_mem[filt_addr];
        if (psum_wr)  ps_mem[psum_addr] <= psum_wdata;
        if (psum_rd)  psum_rdata <= ps_mem[psum_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // strobe protocol monitor
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if ((ifmap_rd && ifmap_wr) || (filt_rd && filt_wr) || (psum_rd && psum_wr))
                fail_now("rd_wr_same_cycle");
            if (dbg_state == ST_IDLE && (ifmap_rd || ifmap_wr || filt_rd || filt_wr || psum_rd || psum_wr))
                fail_now("strobe_in_idle");
        end
    end

`ifdef PE_PSUM_ACC_EN
    int pin_wait;
    initial begin
        pin_wait = 0;
        psum_in_valid = 1'b0;
        psum_in_data = 8'd10;
        forever begin
            @(negedge clk);
            if (psum_in_ready) begin
                if (pin_wait >= 3) psum_in_valid = 1'b1;
                else pin_wait++;
            end else begin
                psum_in_valid = 1'b0;
                pin_wait = 0;
            end
        end
    end
`else
    initial begin
        psum_in_valid = 1'b0;
        psum_in_data = 8'd0;
    end
`endif

    // driver: configure and stream in one job
    task automatic load_job();
        int ii, fi, cyc;
        ii = 0; fi = 0; cyc = 0;
        @(negedge clk);
        cfg_w = 5'(cur_w);
        cfg_s = 4'(cur_s);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("cfg_accept_busy", busy, 1);
        while ((ii < cur_w || fi < cur_s) && cyc < 400) begin
            ifmap_valid = (ii < cur_w) && ($urandom_range(0, 3) != 0);
            ifmap_data  = (ii < 16) ? cur_ifm[ii] : 8'd0;
            filt_valid  = (fi < cur_s) && ($urandom_range(0, 3) != 0);
            filt_data   = (fi < 16) ? cur_flt[fi] : 8'd0;
            if (ifmap_valid && ifmap_ready) ii++;
            if (filt_valid && filt_ready) fi++;
            @(negedge clk);
            cyc++;
        end
        ifmap_valid = 1'b0;
        filt_valid = 1'b0;
        if (cyc >= 400) fail_now("load_timeout");
    endtask

    // wait through COMPUTE and consume DRAIN against exp_q
    task automatic finish_job(input int mode);
        int cyc, comp, hold, since, base;
        bit seen_done, stalled;
        logic [7:0] held;
        cyc = 0; comp = 0; hold = 0; since = 0; seen_done = 0; stalled = 0; held = '0;
        base = (cur_w - cur_s + 1) * (cur_s + 1);
        while (!seen_done && cyc < 3000) begin
            if (dbg_state == ST_COMPUTE) comp++;
            if (done) begin
                seen_done = 1;
                check("done_busy_low", busy, 0);
                check("done_after_last_xfer", since, 1);
                check("all_outputs_drained", exp_q.size(), 0);
            end else if (psum_out_valid) begin
                if (stalled) check("hold_stable", psum_out_data, held);
                if (mode == 1 && hold < 5) begin
                    psum_out_ready = 1'b0;
                    hold++;
                end else if (mode == 0) begin
                    psum_out_ready = 1'($urandom_range(0, 1));
                end else begin
                    psum_out_ready = 1'b1;
                end
                if (psum_out_ready) begin
                    if (exp_q.size() == 0) fail_now("unexpected_output");
                    else check("psum_out", psum_out_data, exp_q.pop_front());
                    since = 0;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = psum_out_data;
                end
            end else begin
                if (stalled) fail_now("valid_dropped_while_stalled");
                stalled = 0;
                psum_out_ready = 1'($urandom_range(0, 1));
            end
            since++;
            @(negedge clk);
            cyc++;
        end
        psum_out_ready = 1'b0;
        if (!seen_done) begin
            fail_now("done_timeout");
            exp_q.delete();
        end else begin
            check("done_pulse_width", done, 0);
`ifdef PE_PSUM_ACC_EN
            check("compute_stalled", comp > base, 1);
`else
            check("compute_cycles", comp, base);
`endif
        end
    endtask

    task automatic use_vec(input int idx);
        cur_w = vecs[idx].w;
        cur_s = vecs[idx].s;
        for (int i = 0; i < 16; i++) begin
            cur_ifm[i] = vecs[idx].ifm[i];
            cur_flt[i] = vecs[idx].flt[i];
        end
    endtask

    initial begin : main
        int err_w[3];
        int err_s[3];
        int cyc;

        // vector table
        for (int v = 0; v < 6; v++) begin
            vecs[v].ifm = '0; vecs[v].flt = '0; vecs[v].exp_o = '0;
        end
        vecs[0].w = 5; vecs[0].s = 3; vecs[0].mode = 2;
        for (int i = 0; i < 5; i++) vecs[0].ifm[i] = 8'(i + 1);
        for (int i = 0; i < 3; i++) vecs[0].flt[i] = 8'd1;
        vecs[0].exp_o[0] = 8'd6; vecs[0].exp_o[1] = 8'd9; vecs[0].exp_o[2] = 8'd12;
        vecs[1].w = 2; vecs[1].s = 1; vecs[1].mode = 2;
        vecs[1].ifm[0] = 8'd200; vecs[1].ifm[1] = 8'd200; vecs[1].flt[0] = 8'd2;
        vecs[1].exp_o[0] = 8'd144; vecs[1].exp_o[1] = 8'd144;
        vecs[2] = vecs[0];
        vecs[2].mode = 1;
        vecs[3].w = 4; vecs[3].s = 4; vecs[3].mode = 0;
        for (int i = 0; i < 4; i++) begin
            vecs[3].ifm[i] = 8'(i + 1);
            vecs[3].flt[i] = 8'(4 - i);
        end
        vecs[3].exp_o[0] = 8'd20;
        vecs[4].w = 16; vecs[4].s = 1; vecs[4].mode = 0;
        vecs[4].flt[0] = 8'd255;
        for (int i = 0; i < 16; i++) begin
            vecs[4].ifm[i] = 8'(i + 1);
            vecs[4].exp_o[i] = 8'(255 - i);
        end
        vecs[5].w = 16; vecs[5].s = 15; vecs[5].mode = 0;
        for (int i = 0; i < 16; i++) begin
            vecs[5].ifm[i] = 8'd1;
            if (i < 15) vecs[5].flt[i] = 8'd1;
        end
        vecs[5].exp_o[0] = 8'd15; vecs[5].exp_o[1] = 8'd15;

        cfg_valid = 0; cfg_w = 0; cfg_s = 0;
        ifmap_valid = 0; ifmap_data = 0; filt_valid = 0; filt_data = 0;
        psum_out_ready = 0;
        rst = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_out_valid", psum_out_valid, 0);
        check("rst_out_data", psum_out_data, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("cfg_ready_after_rst", cfg_ready, 1);

        // illegal configurations
        err_w[0] = 3;  err_s[0] = 4;
        err_w[1] = 5;  err_s[1] = 0;
        err_w[2] = 17; err_s[2] = 2;
        for (int e = 0; e < 3; e++) begin
            cfg_w = 5'(err_w[e]);
            cfg_s = 4'(err_s[e]);
            cfg_valid = 1'b1;
            @(negedge clk);
            cfg_valid = 1'b0;
            check("cfg_err_pulse", cfg_err, 1);
            check("cfg_err_busy", busy, 0);
            check("cfg_err_state", dbg_state, ST_IDLE);
            @(negedge clk);
            check("cfg_err_clears", cfg_err, 0);
            check("cfg_err_busy_after", busy, 0);
        end

        // table vectors
        for (int v = 0; v < 6; v++) begin
            use_vec(v);
            for (int i = 0; i <= cur_w - cur_s; i++)
                exp_q.push_back(8'(int'(vecs[v].exp_o[i]) + PSUM_ADD));
            load_job();
            finish_job(vecs[v].mode);
        end

        // reset in the middle of COMPUTE, then rerun
        use_vec(0);
        load_job();
        cyc = 0;
        while (dbg_state != ST_COMPUTE && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) fail_now("reach_compute_timeout");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_state", dbg_state, ST_IDLE);
        check("midrst_busy", busy, 0);
        check("midrst_cfg_ready", cfg_ready, 0);
        check("midrst_ifmap_rd", ifmap_rd, 0);
        check("midrst_filt_rd", filt_rd, 0);
        check("midrst_psum_wr", psum_wr, 0);
        check("midrst_psum_wdata", psum_wdata, 0);
        check("midrst_out_valid", psum_out_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) exp_q.push_back(8'(int'(vecs[0].exp_o[i]) + PSUM_ADD));
        load_job();
        finish_job(0);

        // random jobs against the reference model
        for (int r = 0; r < 10; r++) begin
            cur_w = $urandom_range(1, 16);
            cur_s = $urandom_range(1, (cur_w > 15) ? 15 : cur_w);
            for (int i = 0; i < 16; i++) begin
                cur_ifm[i] = 8'($urandom_range(0, 255));
                cur_flt[i] = 8'($urandom_range(0, 255));
            end
            for (int jo = 0; jo <= cur_w - cur_s; jo++) begin
                int acc;
                acc = PSUM_ADD;
                for (int t = 0; t < cur_s; t++)
                    acc += int'(cur_ifm[jo + t]) * int'(cur_flt[t]);
                exp_q.push_back(8'(acc % 256));
            end
            load_job();
            finish_job(r % 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL global_timeout (t=%0t)", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, data width of activations, weights and partial sums.
REQ-002 Parameter IFMAP_DEPTH, default 16, ifmap scratchpad entries (address width 4).
REQ-003 Parameter FILT_DEPTH, default 64, filter and psum scratchpad entries (address width 6).
REQ-004 Ports: clk in 1 clock; rst in 1 asynchronous active-low reset.
REQ-005 Config ports: cfg_valid in 1; cfg_ready out 1; cfg_w in 5 (ifmap row length); cfg_s in 4 (filter taps); cfg_err out 1 (one-cycle pulse).
REQ-006 Load stream ports: ifmap_valid in 1, ifmap_ready out 1, ifmap_data in DATA_W; filt_valid in 1, filt_ready out 1, filt_data in DATA_W.
REQ-007 Ifmap scratchpad ports: ifmap_addr out 4, ifmap_wr out 1, ifmap_rd out 1, ifmap_wdata out DATA_W, ifmap_rdata in DATA_W.
REQ-008 Filter scratchpad ports: filt_addr out 6, filt_wr out 1, filt_rd out 1, filt_wdata out DATA_W, filt_rdata in DATA_W.
REQ-009 Psum scratchpad ports: psum_addr out 6, psum_wr out 1, psum_rd out 1, psum_wdata out DATA_W, psum_rdata in DATA_W.
REQ-010 Psum-in ports (used only with PE_PSUM_ACC_EN): psum_in_valid in 1, psum_in_ready out 1, psum_in_data in DATA_W.
REQ-011 Output ports: psum_out_valid out 1, psum_out_ready in 1, psum_out_data out DATA_W; busy out 1; done out 1 (one-cycle pulse).

Function
REQ-012 FSM states SHALL be IDLE, LOAD, COMPUTE, DRAIN; busy high in every state except IDLE.
REQ-013 In IDLE, cfg_ready high; cfg_valid accepted with 1<=cfg_s<=cfg_w<=16 latches W/S and enters LOAD; otherwise cfg_err pulses and FSM stays IDLE.
REQ-014 LOAD: ifmap_ready high until W words accepted, filt_ready high until S words accepted; both streams run concurrently; each accepted word is written the same cycle (wr=1, address = word index 0,1,2...).
REQ-015 LOAD exits to COMPUTE the cycle after both counts are complete.
REQ-016 COMPUTE: for output j=0..W-S, tap k=0..S-1, issue ifmap_rd at addr j+k and filt_rd at addr k; scratchpad read latency is 1 cycle.
REQ-017 Accumulator clears at k=0 of each output; adds ifmap_rdata*filt_rdata, product and sum truncated modulo 2^DATA_W, unsigned.
REQ-018 The cycle after the last tap, accumulator value (plus psum_in_data if enabled) is written to psum addr j; each output takes exactly S+1 cycles when not stalled.
REQ-019 After output W-S is written, FSM enters DRAIN.
REQ-020 DRAIN: psum entries 0..W-S are read in order and presented on psum_out with valid/ready; data SHALL stay stable while valid and not ready.
REQ-021 Transfer completes on valid&&ready; after the last transfer, done pulses and FSM returns to IDLE the next cycle.
REQ-022 Scratchpad rd/wr strobes SHALL be zero in any cycle not listed above; rd and wr never both high on one scratchpad.

Reset
REQ-023 On rst low, FSM to IDLE; all counters, accumulator, strobes, addresses, write data, psum_out_data, psum_out_valid, done, cfg_err, busy to 0; cfg_ready to 0 while rst asserted, 1 after release.
REQ-024 Reset asserted mid-LOAD/COMPUTE/DRAIN abandons the job; scratchpad contents are not cleared.

Configuration
REQ-025 With PE_PSUM_ACC_EN defined, the write cycle of REQ-018 requires psum_in_valid; psum_in_ready asserts in that cycle; FSM stalls until the handshake, then writes acc+psum_in_data.
REQ-026 Without PE_PSUM_ACC_EN, psum_in_ready is tied 0, psum_in ports are ignored and no stall occurs.

Structure
REQ-027 Shared package pe_pkg holds the FSM state enum, DATA_W, and the address widths (4, 6).
REQ-028 One sub-module, pe_mac_acc (multiply-accumulate register with clear), is natural; the FSM and counters stay in pe_sequencer.

Verification
REQ-029 W=5, S=3, ifmap 1,2,3,4,5, filter 1,1,1 -> psum_out 6, 9, 12, then done pulse; COMPUTE lasts 12 cycles.
REQ-030 cfg_s=4, cfg_w=3 -> cfg_err pulse, FSM remains IDLE, busy stays 0.
REQ-031 ifmap 200,200, filter 2, W=2, S=1 -> psum_out 144, 144 (modulo wrap).
REQ-032 psum_out_ready held low 5 cycles in DRAIN -> psum_out_data and valid unchanged, no entry skipped.
REQ-033 rst low during COMPUTE -> all outputs 0 next edge, IDLE, new job after release runs correctly.
REQ-034 PE_PSUM_ACC_EN, case REQ-029, psum_in 10 delayed 3 cycles per output -> outputs 16, 19, 22 with stalls observed.
